line_motor_driver: RTL and testbench

Consumer side of the line-tracker sensor state. Takes the 2-bit tracking state, debounces it, and runs a steering/recovery state machine. Drives two H-bridge motor channels: PWM enables plus IN pins. Slew-limited duty and safe direction reversal protect the gearbox and driver.

---
 rtl/line_motor_driver_pkg.sv | 30 +++
 rtl/line_motor_driver_motor_channel.sv | 98 +++++++++
 rtl/line_motor_driver.sv | 200 ++++++++++++++++++++
 tb/tb_line_motor_driver.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_motor_driver_pkg.sv
// Shared definitions for the line-following motor driver.
// Holds the tracker state encodings, the 3-bit steering mode enum,
// the H-bridge direction codes and the turn-memory encoding.
package line_motor_driver_pkg;

  // Tracker state as delivered by the line sensor front end
  localparam logic [1:0] TRK_LOST       = 2'b00;
  localparam logic [1:0] TRK_LINE_RIGHT = 2'b01;
  localparam logic [1:0] TRK_LINE_LEFT  = 2'b10;
  localparam logic [1:0] TRK_CENTER     = 2'b11;

  // Steering / recovery modes
  typedef enum logic [2:0] {
    MODE_STOP   = 3'd0,
    MODE_FWD    = 3'd1,
    MODE_TURN_L = 3'd2,
    MODE_TURN_R = 3'd3,
    MODE_SEARCH = 3'd4
  } mode_e;

  // H-bridge IN pin patterns
  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_REV   = 2'b01;
  localparam logic [1:0] DIR_COAST = 2'b00;

  // Which side the line was last seen on
  localparam logic TURN_LEFT  = 1'b0;
  localparam logic TURN_RIGHT = 1'b1;

endpackage

// File: rtl/line_motor_driver_motor_channel.sv
// One H-bridge channel: slew-limited duty, safe direction reversal and
// the registered PWM comparator.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   force_stop_i    immediate stop: duty 0, IN=coast, pwm low next cycle
//   wrap_i          high in the last cycle of each PWM period
//   cnt_i           free-running PWM counter value
//   tgt_dir_i       requested bridge direction
//   tgt_duty_i      requested duty
//   pwm_o           registered bridge enable
//   in_o            registered bridge IN pins
module motor_channel
  import line_motor_driver_pkg::*;
#(
  parameter int PWM_BITS  = 10,
  parameter int RAMP_STEP = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                force_stop_i,
  input  logic                wrap_i,
  input  logic [PWM_BITS-1:0] cnt_i,
  input  logic [1:0]          tgt_dir_i,
  input  logic [PWM_BITS-1:0] tgt_duty_i,
  output logic                pwm_o,
  output logic [1:0]          in_o
);

  localparam logic signed [31:0] STEP_S     = 32'(RAMP_STEP);
  localparam logic signed [31:0] DUTY_MAX_S = 32'((1 << PWM_BITS) - 1);

  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [1:0]          dir_q, dir_d;
  logic                pwm_q, pwm_d;

  // Move cur toward tgt by at most RAMP_STEP, clamped to the legal duty range.
  // Done in 32-bit signed so a large RAMP_STEP can never wrap the duty.
  function automatic logic [PWM_BITS-1:0] ramp_toward(
    input logic [PWM_BITS-1:0] cur,
    input logic [PWM_BITS-1:0] tgt
  );
    logic signed [31:0] cur_s;
    logic signed [31:0] tgt_s;
    logic signed [31:0] nxt_s;
    cur_s = $signed({{(32-PWM_BITS){1'b0}}, cur});
    tgt_s = $signed({{(32-PWM_BITS){1'b0}}, tgt});
    if (tgt_s > cur_s + STEP_S) begin
      nxt_s = cur_s + STEP_S;
    end else if (tgt_s < cur_s - STEP_S) begin
      nxt_s = cur_s - STEP_S;
    end else begin
      nxt_s = tgt_s;
    end
    if (nxt_s < 0) begin
      nxt_s = 0;
    end else if (nxt_s > DUTY_MAX_S) begin
      nxt_s = DUTY_MAX_S;
    end
    return nxt_s[PWM_BITS-1:0];
  endfunction

  always_comb begin
    duty_d = duty_q;
    dir_d  = dir_q;
    pwm_d  = (cnt_i < duty_q);
    if (force_stop_i) begin
      duty_d = '0;
      dir_d  = DIR_COAST;
      pwm_d  = 1'b0;
    end else if (wrap_i) begin
      if (duty_q == '0 && dir_q != tgt_dir_i) begin
        // Bridge is de-energised: the only safe moment to change direction.
        dir_d = tgt_dir_i;
      end else if (dir_q != tgt_dir_i) begin
        // Wrong direction while driven: ramp down to zero first.
        duty_d = ramp_toward(duty_q, '0);
      end else begin
        duty_d = ramp_toward(duty_q, tgt_duty_i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      duty_q <= '0;
      dir_q  <= DIR_COAST;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      dir_q  <= dir_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;
  assign in_o  = dir_q;

endmodule

// File: rtl/line_motor_driver.sv
// Line-tracker consumer: debounces the 2-bit tracking state, runs the
// steering/recovery FSM and drives two slew-limited H-bridge channels.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   enable                run permission; low stops both bridges at once
//   state                 tracker state (LOST/LINE_RIGHT/LINE_LEFT/CENTER)
//   left_pwm, right_pwm   registered bridge enables
//   left_in, right_in     registered bridge IN pins (10 fwd, 01 rev, 00 coast)
//   mode                  current FSM mode for debug
module line_motor_driver
  import line_motor_driver_pkg::*;
#(
  parameter int PWM_BITS     = 10,
  parameter int FAST_DUTY    = 800,
  parameter int SLOW_DUTY    = 300,
  parameter int RAMP_STEP    = 64,
  parameter int DEBOUNCE     = 4,
  parameter int LOST_TIMEOUT = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] state,
  output logic       left_pwm,
  output logic       right_pwm,
  output logic [1:0] left_in,
  output logic [1:0] right_in,
  output logic [2:0] mode
);

  localparam int DB_W   = $clog2(DEBOUNCE + 1);
  localparam int LOST_W = $clog2(LOST_TIMEOUT + 1);

  localparam logic [DB_W-1:0]     DB_MAX   = DB_W'(DEBOUNCE);
  localparam logic [LOST_W-1:0]   LOST_MAX = LOST_W'(LOST_TIMEOUT);
  localparam logic [PWM_BITS-1:0] FAST_D   = PWM_BITS'(FAST_DUTY);
  localparam logic [PWM_BITS-1:0] SLOW_D   = PWM_BITS'(SLOW_DUTY);

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic                wrap;

  logic [1:0]      samp_q, samp_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]      acc_q, acc_d;

  mode_e             mode_q, mode_d;
  logic              last_turn_q, last_turn_d;
  logic [LOST_W-1:0] lost_q, lost_d;

  logic [1:0]          l_dir, r_dir;
  logic [PWM_BITS-1:0] l_duty, r_duty;

  // Free-running PWM counter; the all-ones cycle is the period wrap
  assign cnt_d = cnt_q + 1'b1;
  assign wrap  = (cnt_q == '1);

  // Debounce: run length of identical samples, saturating at DEBOUNCE
  always_comb begin
    samp_d   = samp_q;
    db_cnt_d = db_cnt_q;
    acc_d    = acc_q;
    if (state != samp_q) begin
      samp_d   = state;
      db_cnt_d = DB_W'(1);
    end else if (db_cnt_q < DB_MAX) begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
    if (db_cnt_d >= DB_MAX) begin
      acc_d = state;
    end
  end

  // Steering FSM driven by the accepted state
  always_comb begin
    mode_d      = mode_q;
    lost_d      = lost_q;
    last_turn_d = last_turn_q;

    // Turn memory follows the accepted state even while disabled
    if (acc_q == TRK_LINE_LEFT) begin
      last_turn_d = TURN_LEFT;
    end else if (acc_q == TRK_LINE_RIGHT) begin
      last_turn_d = TURN_RIGHT;
    end

    if (!enable) begin
      mode_d = MODE_STOP;
    end else begin
      case (acc_q)
        TRK_CENTER:     mode_d = MODE_FWD;
        TRK_LINE_LEFT:  mode_d = MODE_TURN_L;
        TRK_LINE_RIGHT: mode_d = MODE_TURN_R;
        default: begin
          case (mode_q)
            MODE_FWD, MODE_TURN_L, MODE_TURN_R: begin
              mode_d = MODE_SEARCH;
              lost_d = '0;
            end
            MODE_SEARCH: begin
              if (wrap) begin
                lost_d = lost_q + 1'b1;
                if (lost_d >= LOST_MAX) begin
                  mode_d = MODE_STOP;
                end
              end
            end
            default: mode_d = MODE_STOP;
          endcase
        end
      endcase
    end
  end

  // Per-mode wheel targets; search spins toward the side last seen
  always_comb begin
    l_dir  = DIR_COAST;
    r_dir  = DIR_COAST;
    l_duty = '0;
    r_duty = '0;
    case (mode_q)
      MODE_FWD: begin
        l_dir = DIR_FWD; l_duty = FAST_D;
        r_dir = DIR_FWD; r_duty = FAST_D;
      end
      MODE_TURN_L: begin
        l_dir = DIR_FWD; l_duty = SLOW_D;
        r_dir = DIR_FWD; r_duty = FAST_D;
      end
      MODE_TURN_R: begin
        l_dir = DIR_FWD; l_duty = FAST_D;
        r_dir = DIR_FWD; r_duty = SLOW_D;
      end
      MODE_SEARCH: begin
        l_duty = SLOW_D;
        r_duty = SLOW_D;
        if (last_turn_q == TURN_LEFT) begin
          l_dir = DIR_REV;
          r_dir = DIR_FWD;
        end else begin
          l_dir = DIR_FWD;
          r_dir = DIR_REV;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      samp_q      <= TRK_LOST;
      db_cnt_q    <= '0;
      acc_q       <= TRK_LOST;
      mode_q      <= MODE_STOP;
      last_turn_q <= TURN_LEFT;
      lost_q      <= '0;
    end else begin
      cnt_q       <= cnt_d;
      samp_q      <= samp_d;
      db_cnt_q    <= db_cnt_d;
      acc_q       <= acc_d;
      mode_q      <= mode_d;
      last_turn_q <= last_turn_d;
      lost_q      <= lost_d;
    end
  end

  motor_channel #(
    .PWM_BITS  (PWM_BITS),
    .RAMP_STEP (RAMP_STEP)
  ) u_left (
    .clk          (clk),
    .reset        (reset),
    .force_stop_i (!enable),
    .wrap_i       (wrap),
    .cnt_i        (cnt_q),
    .tgt_dir_i    (l_dir),
    .tgt_duty_i   (l_duty),
    .pwm_o        (left_pwm),
    .in_o         (left_in)
  );

  motor_channel #(
    .PWM_BITS  (PWM_BITS),
    .RAMP_STEP (RAMP_STEP)
  ) u_right (
    .clk          (clk),
    .reset        (reset),
    .force_stop_i (!enable),
    .wrap_i       (wrap),
    .cnt_i        (cnt_q),
    .tgt_dir_i    (r_dir),
    .tgt_duty_i   (r_duty),
    .pwm_o        (right_pwm),
    .in_o         (right_in)
  );

  assign mode = mode_q;

endmodule

// File: tb/tb_line_motor_driver.sv
// Bench for line_motor_driver: directed scenarios followed by random
// state/enable/reset traffic, every output compared each cycle against a
// behavioural model of the steering, debounce and ramp rules.
module tb_line_motor_driver;
  import line_motor_driver_pkg::*;

  localparam int PB     = 4;
  localparam int PERIOD = 16;
  localparam int FAST   = 12;
  localparam int SLOW   = 4;
  localparam int STEP   = 4;
  localparam int DEB    = 3;
  localparam int LTO    = 2;

  localparam int M_STOP   = int'(MODE_STOP);
  localparam int M_FWD    = int'(MODE_FWD);
  localparam int M_TURN_L = int'(MODE_TURN_L);
  localparam int M_TURN_R = int'(MODE_TURN_R);
  localparam int M_SEARCH = int'(MODE_SEARCH);

  // tracker states and bridge codes as plain numbers
  localparam int S_LOST = 0, S_RIGHT = 1, S_LEFT = 2, S_CENTER = 3;
  localparam int D_COAST = 0, D_REV = 1, D_FWD = 2;

  logic       clk = 1'b0;
  logic       reset, enable;
  logic [1:0] state;
  logic       left_pwm, right_pwm;
  logic [1:0] left_in, right_in;
  logic [2:0] mode;

  line_motor_driver #(
    .PWM_BITS(PB), .FAST_DUTY(FAST), .SLOW_DUTY(SLOW),
    .RAMP_STEP(STEP), .DEBOUNCE(DEB), .LOST_TIMEOUT(LTO)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .state(state),
    .left_pwm(left_pwm), .right_pwm(right_pwm),
    .left_in(left_in), .right_in(right_in), .mode(mode)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model
  int m_cnt, m_acc, m_mode, m_last, m_lost;
  int m_duty[2], m_dir[2], m_pwm[2];
  int hist[$];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_acc = S_LOST; m_mode = M_STOP; m_last = 0; m_lost = 0;
    for (int c = 0; c < 2; c++) begin
      m_duty[c] = 0; m_dir[c] = D_COAST; m_pwm[c] = 0;
    end
    hist.delete();
  endtask

  // One clock edge of the specified behaviour, using pre-edge values.
  task automatic model_edge();
    int  o_cnt, o_acc, o_mode, o_last, o_lost;
    int  o_duty[2];
    int  o_dir[2];
    int  tdir[2];
    int  tduty[2];
    int  goal, diff, mv;
    bit  wrap, stable;
    if (reset) begin
      model_reset();
      return;
    end
    o_cnt = m_cnt; o_acc = m_acc; o_mode = m_mode; o_last = m_last; o_lost = m_lost;
    o_duty = m_duty; o_dir = m_dir;
    wrap  = (o_cnt == PERIOD - 1);
    m_cnt = (o_cnt + 1) % PERIOD;

    // accept a state once the last DEB samples all agree
    hist.push_back(int'(state));
    if (hist.size() > DEB) void'(hist.pop_front());
    if (hist.size() == DEB) begin
      stable = 1'b1;
      foreach (hist[i]) if (hist[i] != hist[0]) stable = 1'b0;
      if (stable) m_acc = hist[0];
    end

    if (o_acc == S_LEFT) m_last = 0;
    else if (o_acc == S_RIGHT) m_last = 1;

    if (!enable) m_mode = M_STOP;
    else if (o_acc == S_CENTER) m_mode = M_FWD;
    else if (o_acc == S_LEFT) m_mode = M_TURN_L;
    else if (o_acc == S_RIGHT) m_mode = M_TURN_R;
    else if (o_mode == M_FWD || o_mode == M_TURN_L || o_mode == M_TURN_R) begin
      m_mode = M_SEARCH; m_lost = 0;
    end else if (o_mode == M_SEARCH && wrap) begin
      m_lost = o_lost + 1;
      if (m_lost >= LTO) m_mode = M_STOP;
    end

    // wheel targets from the mode table
    tdir[0] = D_COAST; tdir[1] = D_COAST; tduty[0] = 0; tduty[1] = 0;
    if (o_mode == M_FWD) begin
      tdir = '{D_FWD, D_FWD}; tduty = '{FAST, FAST};
    end else if (o_mode == M_TURN_L) begin
      tdir = '{D_FWD, D_FWD}; tduty = '{SLOW, FAST};
    end else if (o_mode == M_TURN_R) begin
      tdir = '{D_FWD, D_FWD}; tduty = '{FAST, SLOW};
    end else if (o_mode == M_SEARCH) begin
      tduty = '{SLOW, SLOW};
      tdir  = (o_last == 0) ? '{D_REV, D_FWD} : '{D_FWD, D_REV};
    end

    for (int c = 0; c < 2; c++) begin
      m_pwm[c] = (enable && (o_cnt < o_duty[c])) ? 1 : 0;
      if (!enable) begin
        m_duty[c] = 0; m_dir[c] = D_COAST;
      end else if (wrap) begin
        if (o_duty[c] == 0 && o_dir[c] != tdir[c]) begin
          m_dir[c] = tdir[c];
        end else begin
          goal = (o_dir[c] != tdir[c]) ? 0 : tduty[c];
          diff = goal - o_duty[c];
          mv   = (diff < 0) ? -diff : diff;
          if (mv > STEP) mv = STEP;
          m_duty[c] = o_duty[c] + ((diff < 0) ? -mv : mv);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("left_pwm",  int'(left_pwm),  m_pwm[0]);
    chk("right_pwm", int'(right_pwm), m_pwm[1]);
    chk("left_in",   int'(left_in),   m_dir[0]);
    chk("right_in",  int'(right_in),  m_dir[1]);
    chk("mode",      int'(mode),      m_mode);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic count_highs(output int lh, output int rh);
    lh = 0; rh = 0;
    for (int i = 0; i < PERIOD; i++) begin
      step();
      lh += int'(left_pwm);
      rh += int'(right_pwm);
    end
  endtask

  initial begin
    int lh, rh, budget, left_cycles;
    bit reached;

    // reset with CENTER already presented
    reset = 1'b1; enable = 1'b1; state = 2'(S_CENTER);
    model_reset();
    steps(2);
    chk("rst_mode", int'(mode), M_STOP);
    chk("rst_left_pwm", int'(left_pwm), 0);
    chk("rst_right_pwm", int'(right_pwm), 0);
    chk("rst_left_in", int'(left_in), D_COAST);
    chk("rst_right_in", int'(right_in), D_COAST);

    // straight run: FWD four cycles after release, ramp to FAST
    reset = 1'b0;
    steps(3);
    chk("mode_before_fwd", int'(mode), M_STOP);
    step();
    chk("mode_fwd_latency", int'(mode), M_FWD);
    steps(76);
    count_highs(lh, rh);
    chk("fwd_left_highs", lh, FAST);
    chk("fwd_right_highs", rh, FAST);
    chk("fwd_left_in", int'(left_in), D_FWD);
    chk("fwd_right_in", int'(right_in), D_FWD);

    // two-cycle glitch must be rejected by the debouncer
    state = 2'(S_LEFT); steps(2);
    state = 2'(S_CENTER); steps(8);
    chk("glitch_mode", int'(mode), M_FWD);

    // sustained LINE_LEFT: inner wheel slows, outer stays fast
    state = 2'(S_LEFT); steps(60);
    chk("turn_mode", int'(mode), M_TURN_L);
    count_highs(lh, rh);
    chk("turn_left_highs", lh, SLOW);
    chk("turn_right_highs", rh, FAST);

    // line lost: search with left wheel reversed, then timeout to STOP
    state = 2'(S_LOST);
    reached = 1'b0;
    budget = 0;
    while (!reached && budget < 60) begin
      step(); budget++;
      if (int'(left_in) == D_REV) reached = 1'b1;
    end
    chk("search_left_reversed", int'(reached), 1);
    steps(160);
    chk("timeout_mode", int'(mode), M_STOP);
    chk("timeout_left_in", int'(left_in), D_COAST);
    chk("timeout_right_in", int'(right_in), D_COAST);

    // enable drop mid-ramp at duty 8
    state = 2'(S_CENTER);
    reached = 1'b0;
    budget = 0;
    while (!reached && budget < 200) begin
      step(); budget++;
      if (m_duty[0] == 8 && m_dir[0] == D_FWD) reached = 1'b1;
    end
    chk("duty8_reached", int'(reached), 1);
    enable = 1'b0;
    step();
    chk("dis_left_pwm", int'(left_pwm), 0);
    chk("dis_right_pwm", int'(right_pwm), 0);
    chk("dis_left_in", int'(left_in), D_COAST);
    chk("dis_right_in", int'(right_in), D_COAST);
    chk("dis_mode", int'(mode), M_STOP);
    steps(5);
    enable = 1'b1;
    steps(80);
    chk("reenable_mode", int'(mode), M_FWD);
    count_highs(lh, rh);
    chk("reenable_left_highs", lh, FAST);

    // reset in the middle of a search reversal
    state = 2'(S_LEFT); steps(60);
    state = 2'(S_LOST);
    reached = 1'b0;
    budget = 0;
    while (!reached && budget < 50) begin
      step(); budget++;
      if (int'(mode) == M_SEARCH) reached = 1'b1;
    end
    chk("search_reached", int'(reached), 1);
    steps(10);
    reset = 1'b1;
    step();
    chk("midrst_mode", int'(mode), M_STOP);
    chk("midrst_left_pwm", int'(left_pwm), 0);
    chk("midrst_right_pwm", int'(right_pwm), 0);
    chk("midrst_left_in", int'(left_in), D_COAST);
    chk("midrst_right_in", int'(right_in), D_COAST);
    reset = 1'b0;

    // random traffic
    left_cycles = 2000;
    while (left_cycles > 0) begin
      int hold;
      state  = 2'($urandom_range(0, 3));
      enable = ($urandom_range(0, 9) != 0);
      reset  = ($urandom_range(0, 39) == 0);
      step(); left_cycles--;
      reset = 1'b0;
      hold = $urandom_range(0, 45);
      for (int i = 0; i < hold && left_cycles > 0; i++) begin
        step(); left_cycles--;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
